// File: rtl/e_cycle_scheduler_pkg.sv
// e_cycle_scheduler_pkg: shared FSM states and E-period phase constants for the 6800 E-cycle scheduler.
package e_cycle_scheduler_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_ACTIVE, ST_FINISH} state_t;
  localparam int E_PERIOD = 10;
  localparam logic [3:0] PH_VMA = 4'd4;
  localparam logic [3:0] PH_ELOW_LAST = 4'd5;
  localparam logic [3:0] PH_LAST = 4'd9;
  localparam logic [3:0] PH_ARM_LAST = PH_VMA - 4'd1;
  localparam logic [3:0] PH_SYNC_LOAD = 4'd2;
endpackage

// File: rtl/e_cycle_scheduler_phase.sv
// e_phase_gen: E-period phase counter and E generation; with EXT_E_SYNC_EN it locks to an external E instead.
module e_phase_gen
  import e_cycle_scheduler_pkg::*;
(
  input  logic       i_c7m,
  input  logic       i_rst_n,
  input  logic       i_e,
  output logic       o_e,
  output logic [3:0] o_ph,
  output logic       o_synced
);
  logic [3:0] r_ph;
  logic [3:0] w_ph_inc;
  assign w_ph_inc = (r_ph == PH_LAST) ? 4'd0 : r_ph + 4'd1;
  assign o_ph = r_ph;
`ifdef EXT_E_SYNC_EN
  logic r_s1, r_s2, r_s3, r_sync;
  logic w_fall;
  assign w_fall = r_s3 & ~r_s2;
  // The fall is seen two C7M late through the synchronizer, so PH is reloaded at 2, not 0.
  always_ff @(negedge i_c7m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
      r_sync <= 1'b0;
      r_ph <= 4'd0;
    end else begin
      r_s1 <= i_e;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_sync <= r_sync | w_fall;
      r_ph <= w_fall ? PH_SYNC_LOAD : (r_sync ? w_ph_inc : 4'd0);
    end
  end
  assign o_synced = r_sync;
  assign o_e = 1'b0;
`else
  logic w_unused_e;
  assign w_unused_e = i_e;
  always_ff @(negedge i_c7m or negedge i_rst_n) begin
    if (!i_rst_n) r_ph <= PH_ELOW_LAST;
    else r_ph <= w_ph_inc;
  end
  assign o_synced = 1'b1;
  assign o_e = r_ph > PH_ELOW_LAST;
`endif
endmodule

// File: rtl/e_cycle_scheduler.sv
// e_cycle_scheduler: round-robin arbiter running whole 6800 E-synchronous bus cycles for NREQ requesters.
// Define EXT_E_SYNC_EN to lock the phase to motherboard E_IN instead of generating E_OUT.
module e_cycle_scheduler
  import e_cycle_scheduler_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int E_PERIOD = 10
) (
  input  logic            C7M,
  input  logic            RESET_n,
  input  logic            E_IN,
  output logic            E_OUT,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ-1:0] RW,
  output logic [NREQ-1:0] GNT,
  output logic [NREQ-1:0] DONE,
  output logic            VMA_n,
  output logic            BUS_RW,
  output logic            DLATCH,
  output logic            SYNCED
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  if (E_PERIOD != e_cycle_scheduler_pkg::E_PERIOD) begin : g_bad_period
    $error("E_PERIOD must be 10");
  end
  state_t r_state;
  logic [NREQ-1:0] r_gnt, r_done;
  logic [IW-1:0] r_gidx, r_last, w_pick, w_idx;
  logic r_vma_n, r_bus_rw, r_dlatch;
  logic [3:0] w_ph;
  logic w_synced;
  e_phase_gen u_phase (
    .i_c7m   (C7M),
    .i_rst_n (RESET_n),
    .i_e     (E_IN),
    .o_e     (E_OUT),
    .o_ph    (w_ph),
    .o_synced(w_synced)
  );
  // Scan from the farthest index down so the nearest requester after r_last wins.
  always_comb begin
    w_pick = r_last;
    w_idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      w_idx = IW'((int'(r_last) + i) % NREQ);
      if (REQ[w_idx]) w_pick = w_idx;
    end
  end
  always_ff @(negedge C7M or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state <= ST_IDLE;
      r_gnt <= '0;
      r_done <= '0;
      r_gidx <= '0;
      r_last <= IW'(NREQ - 1);
      r_vma_n <= 1'b1;
      r_bus_rw <= 1'b1;
      r_dlatch <= 1'b0;
    end else begin
      r_done <= '0;
      r_dlatch <= 1'b0;
      case (r_state)
        ST_IDLE:
          if (w_synced && (|REQ) && w_ph <= PH_ARM_LAST) begin
            r_gnt <= NREQ'(1) << w_pick;
            r_gidx <= w_pick;
            r_last <= w_pick;
            r_state <= (w_ph == PH_ARM_LAST) ? ST_ACTIVE : ST_ARMED;
            r_vma_n <= w_ph != PH_ARM_LAST;
            r_bus_rw <= (w_ph == PH_ARM_LAST) ? RW[w_pick] : 1'b1;
          end
        ST_ARMED:
          if (!REQ[r_gidx]) begin
            r_state <= ST_IDLE;
            r_gnt <= '0;
          end else if (w_ph == PH_ARM_LAST) begin
            r_state <= ST_ACTIVE;
            r_vma_n <= 1'b0;
            r_bus_rw <= RW[r_gidx];
          end
        ST_ACTIVE: begin
          r_dlatch <= w_ph == PH_LAST - 4'd1;
          if (w_ph == PH_LAST) begin
            r_state <= ST_FINISH;
            r_vma_n <= 1'b1;
            r_bus_rw <= 1'b1;
            r_done[r_gidx] <= 1'b1;
            r_gnt <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign GNT = r_gnt;
  assign DONE = r_done;
  assign VMA_n = r_vma_n;
  assign BUS_RW = r_bus_rw;
  assign DLATCH = r_dlatch;
  assign SYNCED = w_synced;
endmodule

// File: tb/tb_e_cycle_scheduler.sv
// tb_e_cycle_scheduler: directed vector table plus hand-written multi-cycle sequences for e_cycle_scheduler.
module tb_e_cycle_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, e_in = 1'b1;
  logic [1:0] req = 2'b00, rw = 2'b00;
  logic e_out, vma_n, bus_rw, dlatch, synced;
  logic [1:0] gnt, done;
  int n_tests = 0, n_fail = 0, tb_ph = 5;
  typedef struct {
    logic [1:0] req, rw, gnt, done;
    logic vma_n, bus_rw, dl;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  e_cycle_scheduler #(.NREQ(2), .E_PERIOD(10)) dut (
    .C7M(clk), .RESET_n(rst_n), .E_IN(e_in), .E_OUT(e_out), .REQ(req), .RW(rw),
    .GNT(gnt), .DONE(done), .VMA_n(vma_n), .BUS_RW(bus_rw), .DLATCH(dlatch), .SYNCED(synced)
  );
  always @(negedge clk) tb_ph <= !rst_n ? 5 : (tb_ph == 9 ? 0 : tb_ph + 1);
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
  endtask
  task automatic add(input int n, input logic [1:0] rq, r, g, d, input logic v, b, l);
    vec_t x;
    x.req = rq; x.rw = r; x.gnt = g; x.done = d; x.vma_n = v; x.bus_rw = b; x.dl = l;
    for (int k = 0; k < n; k++) tbl.push_back(x);
  endtask
`ifdef EXT_E_SYNC_EN
  task automatic run();
    repeat (3) @(posedge clk);
    chk("ext_reset", {synced, vma_n, e_out, gnt}, {1'b0, 1'b1, 1'b0, 2'b00});
    rst_n = 1'b1;
    req = 2'b01;
    rw = 2'b01;
    for (int c = 0; c < 16; c++) begin
      int d;
      d = c - 4;
      e_in = (c < 4) ? 1'b1 : (((c - 4) % 10) >= 6);
      cyc();
      chk($sformatf("ext_synced%0d", c), synced, d >= 2);
      chk($sformatf("ext_vma%0d", c), vma_n, !(d >= 4 && d <= 9));
      chk($sformatf("ext_done%0d", c), done, (d == 10) ? 2'b01 : 2'b00);
      chk("ext_e_out", e_out, 0);
    end
  endtask
`else
  task automatic run();
    int ndone, last_c, exp_idx, lat;
    repeat (3) @(posedge clk);
    chk("reset_outs", {gnt, done, vma_n, bus_rw, dlatch, e_out, synced}, 9'b0000_11001);
    // read by requester 0 rising at PH=1
    add(6, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
    add(2, 2'b01, 2'b01, 2'b01, 2'b00, 1, 1, 0);
    add(5, 2'b01, 2'b01, 2'b01, 2'b00, 0, 1, 0);
    add(1, 2'b01, 2'b01, 2'b01, 2'b00, 0, 1, 1);
    add(1, 2'b01, 2'b01, 2'b00, 2'b01, 1, 1, 0);
    // write by requester 1 rising at PH=5 waits for the next period
    add(5, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
    add(5, 2'b10, 2'b00, 2'b00, 2'b00, 1, 1, 0);
    add(3, 2'b10, 2'b00, 2'b10, 2'b00, 1, 1, 0);
    add(5, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0);
    add(1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 1);
    add(1, 2'b10, 2'b00, 2'b00, 2'b10, 1, 1, 0);
    add(1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
    // grant withdrawn at PH=3
    add(2, 2'b01, 2'b01, 2'b01, 2'b00, 1, 1, 0);
    add(1, 2'b00, 2'b01, 2'b00, 2'b00, 1, 1, 0);
    add(3, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
    // request at PH=3 is still a full cycle
    add(6, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
    add(5, 2'b01, 2'b00, 2'b01, 2'b00, 0, 0, 0);
    add(1, 2'b01, 2'b00, 2'b01, 2'b00, 0, 0, 1);
    add(1, 2'b01, 2'b00, 2'b00, 2'b01, 1, 1, 0);
    add(4, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
    // request at PH=4 waits
    add(6, 2'b01, 2'b01, 2'b00, 2'b00, 1, 1, 0);
    add(1, 2'b01, 2'b01, 2'b01, 2'b00, 1, 1, 0);
    add(1, 2'b00, 2'b01, 2'b00, 2'b00, 1, 1, 0);
    add(5, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      req = tbl[i].req;
      rw = tbl[i].rw;
      cyc();
      chk($sformatf("vec%0d", i), {gnt, done, vma_n, bus_rw, dlatch},
          {tbl[i].gnt, tbl[i].done, tbl[i].vma_n, tbl[i].bus_rw, tbl[i].dl});
      chk($sformatf("e_out%0d", i), e_out, tb_ph >= 6);
    end
    // both held: alternating owners, one DONE per E period
    req = 2'b11;
    rw = 2'b10;
    ndone = 0;
    last_c = 0;
    exp_idx = 1;
    for (int c = 0; c < 60 && ndone < 4; c++) begin
      cyc();
      chk("onehot_gnt", $onehot0(gnt), 1);
      if (done != 2'b00) begin
        chk($sformatf("alt_done%0d", ndone), done, (exp_idx == 1) ? 2'b10 : 2'b01);
        if (ndone > 0) chk("done_spacing", c - last_c, 10);
        last_c = c;
        ndone++;
        exp_idx ^= 1;
      end
    end
    chk("alt_count", ndone, 4);
    req = 2'b00;
    cyc();
    cyc();
    // reset in the middle of an owned cycle
    req = 2'b10;
    rw = 2'b00;
    for (int c = 0; c < 30 && vma_n; c++) cyc();
    chk("vma_before_reset", vma_n, 0);
    for (int c = 0; c < 10 && tb_ph != 7; c++) cyc();
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {gnt, done, vma_n, bus_rw, dlatch}, 7'b0000_110);
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("rst_no_done", done, 2'b00);
    end
    req = 2'b11;
    rw = 2'b11;
    rst_n = 1'b1;
    lat = 0;
    for (int c = 0; c < 20 && gnt == 2'b00; c++) begin cyc(); lat++; end
    chk("post_rst_gnt", gnt, 2'b01);
    for (int c = 0; c < 20 && done == 2'b00; c++) begin cyc(); lat++; end
    chk("post_rst_done", done, 2'b01);
    chk("latency_le20", lat <= 20, 1);
    req = 2'b00;
    cyc();
  endtask
`endif
  initial begin
    run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/e_cycle_scheduler.md
E_CYCLE_SCHEDULER -- requirements
Module: e_cycle_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters sharing the E-synchronous (6800) bus.
REQ-002 SHALL have parameter E_PERIOD, default 10, C7M cycles per E period; legal range 10 only, checked at elaboration.
REQ-003 SHALL have ports in this order:
- C7M  in  1  sole clock; all logic on negedge C7M.
- RESET_n  in  1  reset, asynchronous, active-low.
- E_IN  in  1  motherboard E, used only with EXT_E_SYNC_EN.
- E_OUT  out  1  generated E, used only without EXT_E_SYNC_EN.
- REQ  in  NREQ  per-requester cycle request, level, held until DONE.
- RW  in  NREQ  per-requester direction, 1 = read.
- GNT  out  NREQ  one-hot grant, held for the whole owned cycle.
- DONE  out  NREQ  one-C7M pulse per completed cycle.
- VMA_n  out  1  valid memory address to bus, active-low.
- BUS_RW  out  1  direction of the granted cycle; 1 when idle.
- DLATCH  out  1  one-C7M data-latch strobe at end of E-high.
- SYNCED  out  1  phase counter locked to E.

Function
REQ-004 SHALL keep a phase counter PH 0..9, incrementing each C7M and wrapping 9->0; E is low in PH 0..5 and high in PH 6..9.
REQ-005 SHALL implement states IDLE, ARMED, ACTIVE, FINISH.
REQ-006 IDLE->ARMED when SYNCED=1, any REQ=1 and PH<=3; GNT set in the same transition.
REQ-007 A request arriving at PH>=4 SHALL wait in IDLE for PH=0 of the next period; no partial cycles.
REQ-008 ARMED->ACTIVE at PH=4: VMA_n=0 and BUS_RW=RW[granted].
REQ-009 ARMED->IDLE with GNT cleared if the granted REQ drops before PH=4; no DONE, VMA_n untouched.
REQ-010 ACTIVE SHALL NOT abort: REQ drop after VMA_n=0 is ignored until FINISH.
REQ-011 DLATCH SHALL pulse at PH=9 in ACTIVE; ACTIVE->FINISH at PH=9->0.
REQ-012 FINISH, during PH=0: VMA_n=1, BUS_RW=1, DONE[granted]=1, GNT cleared; -> IDLE next C7M.
REQ-013 Latency SHALL be at most 20 C7M from REQ rise to DONE, excluding wait for other requesters.
REQ-014 Arbitration SHALL be round-robin: search starts at the index after the last granted; after reset the last-granted pointer is NREQ-1, so requester 0 wins first.
REQ-015 Simultaneous REQ rises SHALL be resolved by REQ-014 in one C7M; exactly one GNT bit is high at any time.
REQ-016 A requester holding REQ after DONE SHALL be re-arbitrated in the next eligible window, behind any other pending requester.

Reset
REQ-017 RESET_n low SHALL asynchronously force: state IDLE, GNT=0, DONE=0, VMA_n=1, BUS_RW=1, DLATCH=0, last-granted pointer NREQ-1.
REQ-018 Without EXT_E_SYNC_EN, reset SHALL set PH=5, E_OUT=0, SYNCED=1; E_OUT is 1 from the first PH=6 after release.
REQ-019 With EXT_E_SYNC_EN, reset SHALL clear SYNCED and the E synchronizer; PH is held at 0.
REQ-020 Reset mid-ACTIVE SHALL release VMA_n immediately and SHALL NOT emit DONE.

Configuration
REQ-021 Macro EXT_E_SYNC_EN, when defined:
- E_IN passes a 2-flop synchronizer.
- A detected falling edge loads PH=2 to compensate synchronizer latency and sets SYNCED=1.
- Later falling edges re-load PH.
- E_OUT is tied 0.
- No grant is given while SYNCED=0.
REQ-022 Without EXT_E_SYNC_EN: E_OUT is generated from PH; E_IN is ignored; SYNCED is constant 1 after reset.

Structure
REQ-023 Shared package SHALL hold the state enum, PH_VMA=4, PH_ELOW_LAST=5, PH_LAST=9, E_PERIOD.
REQ-024 Sub-module e_phase_gen SHALL contain the phase counter, E_OUT generation and the EXT_E_SYNC_EN synchronizer, outputting PH and SYNCED.

Verification
REQ-025 Read, REQ[0] rises at PH=1 -> GNT=01 same C7M; VMA_n low at PH=4; DLATCH at PH=9; DONE[0] at next PH=0; BUS_RW=1 throughout.
REQ-026 REQ[1] rises at PH=5 -> no GNT until next PH=0; VMA_n low 4 C7M later.
REQ-027 REQ=11 held continuously -> grants alternate 0,1,0,1; one DONE per 10 C7M.
REQ-028 REQ[0] drops at PH=3 after grant -> GNT cleared, VMA_n stays 1, no DONE.
REQ-029 RESET_n low at PH=7 of ACTIVE -> VMA_n=1 asynchronously, no DONE; first cycle after release is served by requester 0.
REQ-030 EXT_E_SYNC_EN, E_IN 6-low/4-high -> SYNCED rises after first falling edge + 2 C7M; VMA_n falls 4 C7M after the E falling edge.
